toy_intr_ctrl: RTL and testbench

Interrupt controller sitting between the interrupt edge-sync stage and the core's trap/commit logic. It latches single-cycle sync pulses (external, software, debug, optional timer) into pending bits and applies CSR enables. It selects one source by fixed priority and presents it to the core over a valid/ready handshake with a 4-bit cause op. It then holds off further requests until the core signals handler completion (intr_clr) or a busy timeout expires.

---
 rtl/toy_intr_pkg.sv | 23 ++
 rtl/toy_intr_ctrl_prio_enc.sv | 33 +++
 rtl/toy_intr_ctrl.sv | 124 ++++++++++++
 tb/tb_toy_intr_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/toy_intr_pkg.sv
// Shared constants for the toy interrupt controller: cause codes, pending-bit
// positions and controller states.
package toy_intr_pkg;

    localparam logic [3:0] INTR_OP_SW    = 4'd3;
    localparam logic [3:0] INTR_OP_TIMER = 4'd7;
    localparam logic [3:0] INTR_OP_EXT   = 4'd11;
    localparam logic [3:0] INTR_OP_DEBUG = 4'd15;

    // Bit positions inside intr_pend = {debug, ext, timer, sw}
    localparam int PEND_SW    = 0;
    localparam int PEND_TIMER = 1;
    localparam int PEND_EXT   = 2;
    localparam int PEND_DEBUG = 3;
    localparam int NUM_SRC    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } intr_state_e;

endpackage

// File: rtl/toy_intr_ctrl_prio_enc.sv
// Fixed-priority selector: debug > ext > sw > timer. Returns the cause code
// and a one-hot grant naming the pending bit to clear on acceptance.
module toy_intr_prio_enc
    import toy_intr_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [NUM_SRC-1:0] eligible,
    output logic               any,
    output logic [OP_W-1:0]    op,
    output logic [NUM_SRC-1:0] grant
);

    always_comb begin
        any   = |eligible;
        op    = '0;
        grant = '0;
        if (eligible[PEND_DEBUG]) begin
            op                = OP_W'(INTR_OP_DEBUG);
            grant[PEND_DEBUG] = 1'b1;
        end else if (eligible[PEND_EXT]) begin
            op              = OP_W'(INTR_OP_EXT);
            grant[PEND_EXT] = 1'b1;
        end else if (eligible[PEND_SW]) begin
            op             = OP_W'(INTR_OP_SW);
            grant[PEND_SW] = 1'b1;
        end else if (eligible[PEND_TIMER]) begin
            op                = OP_W'(INTR_OP_TIMER);
            grant[PEND_TIMER] = 1'b1;
        end
    end

endmodule

// File: rtl/toy_intr_ctrl.sv
// Interrupt controller: latches sync pulses, masks with CSR enables and hands one
// cause at a time to the core. Timer source is present only with TOY_INTR_TIMER_EN.
module toy_intr_ctrl
    import toy_intr_pkg::*;
#(
    parameter int OP_W         = 4,
    parameter int BUSY_TIMEOUT = 0,
    parameter int TO_CNT_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            intr_meip_sync,
    input  logic            intr_msip_sync,
    input  logic            intr_debug_sync,
`ifdef TOY_INTR_TIMER_EN
    input  logic            intr_mtip_sync,
`endif
    input  logic            csr_mstatus_mie,
    input  logic            csr_mie_meie,
    input  logic            csr_mie_msie,
`ifdef TOY_INTR_TIMER_EN
    input  logic            csr_mie_mtie,
`endif
    output logic            intr_vld,
    output logic [OP_W-1:0] intr_op,
    input  logic            intr_rdy,
    input  logic            intr_clr,
    output logic [3:0]      intr_pend,
    output logic            intr_timeout
);

    localparam bit                  TIMEOUT_EN = (BUSY_TIMEOUT > 0);
    localparam logic [TO_CNT_W-1:0] TO_LAST    = TO_CNT_W'(TIMEOUT_EN ? BUSY_TIMEOUT - 1 : 0);

    intr_state_e          state_reg, state_next;
    logic [NUM_SRC-1:0]   pend_reg, pend_next;
    logic [NUM_SRC-1:0]   grant_reg;
    logic [OP_W-1:0]      op_reg;
    logic [TO_CNT_W-1:0]  cnt_reg;
    logic                 timeout_reg, timeout_fire;
    logic [NUM_SRC-1:0]   pulse, eligible, enc_grant;
    logic [OP_W-1:0]      enc_op;
    logic                 enc_any, handshake, timer_en;

    assign pulse[PEND_SW]    = intr_msip_sync;
    assign pulse[PEND_EXT]   = intr_meip_sync;
    assign pulse[PEND_DEBUG] = intr_debug_sync;
`ifdef TOY_INTR_TIMER_EN
    assign pulse[PEND_TIMER] = intr_mtip_sync;
    assign timer_en          = csr_mie_mtie;
`else
    assign pulse[PEND_TIMER] = 1'b0;
    assign timer_en          = 1'b0;
`endif

    // Debug ignores the global enable; machine-level sources need mie plus their own enable.
    assign eligible[PEND_DEBUG] = pend_reg[PEND_DEBUG];
    assign eligible[PEND_EXT]   = pend_reg[PEND_EXT]   & csr_mstatus_mie & csr_mie_meie;
    assign eligible[PEND_SW]    = pend_reg[PEND_SW]    & csr_mstatus_mie & csr_mie_msie;
    assign eligible[PEND_TIMER] = pend_reg[PEND_TIMER] & csr_mstatus_mie & timer_en;

    toy_intr_prio_enc #(.OP_W(OP_W)) u_prio_enc (
        .eligible (eligible),
        .any      (enc_any),
        .op       (enc_op),
        .grant    (enc_grant)
    );

    assign handshake = intr_vld & intr_rdy;
    // OR-ing the new pulse after the clear lets a same-cycle edge re-pend the source.
    assign pend_next = (pend_reg & ~(handshake ? grant_reg : '0)) | pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next   = state_reg;
        timeout_fire = 1'b0;
        case (state_reg)
            IDLE: if (enc_any) state_next = REQ;
            REQ:  if (intr_rdy) state_next = BUSY;
            BUSY: begin
                if (intr_clr) begin
                    state_next = IDLE;
                end else if (TIMEOUT_EN && cnt_reg == TO_LAST) begin
                    state_next   = IDLE;
                    timeout_fire = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        intr_vld = (state_reg == REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg    <= '0;
            grant_reg   <= '0;
            op_reg      <= '0;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            pend_reg    <= pend_next;
            timeout_reg <= timeout_fire;
            if (state_reg == IDLE && enc_any) begin
                op_reg    <= enc_op;
                grant_reg <= enc_grant;
            end
            // Held at zero outside BUSY so every BUSY stay starts counting from 0.
            if (state_reg == BUSY) cnt_reg <= cnt_reg + 1'b1;
            else                   cnt_reg <= '0;
        end
    end

    assign intr_op      = op_reg;
    assign intr_pend    = pend_reg;
    assign intr_timeout = timeout_reg;

endmodule

// File: tb/tb_toy_intr_ctrl.sv
// Randomised scoreboard bench for toy_intr_ctrl (BUSY_TIMEOUT=8) against a
// cycle-level reference of the controller's rules.
module tb_toy_intr_ctrl;

    localparam int TO      = 8;
    localparam int NCYC    = 4000;
    localparam int ORDER [4] = '{3, 2, 0, 1};     // debug, ext, sw, timer
    localparam int OPS   [4] = '{3, 7, 11, 15};   // indexed by pending bit

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       meip = 1'b0, msip = 1'b0, dbg = 1'b0, mtip = 1'b0;
    logic       mie = 1'b0, meie = 1'b0, msie = 1'b0, mtie = 1'b0;
    logic       rdy = 1'b0, clr = 1'b0;
    logic       intr_vld, intr_timeout;
    logic [3:0] intr_op, intr_pend;

    always #5 clk = ~clk;

    toy_intr_ctrl #(.OP_W(4), .BUSY_TIMEOUT(TO), .TO_CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .intr_meip_sync  (meip),
        .intr_msip_sync  (msip),
        .intr_debug_sync (dbg),
`ifdef TOY_INTR_TIMER_EN
        .intr_mtip_sync  (mtip),
`endif
        .csr_mstatus_mie (mie),
        .csr_mie_meie    (meie),
        .csr_mie_msie    (msie),
`ifdef TOY_INTR_TIMER_EN
        .csr_mie_mtie    (mtie),
`endif
        .intr_vld        (intr_vld),
        .intr_op         (intr_op),
        .intr_rdy        (rdy),
        .intr_clr        (clr),
        .intr_pend       (intr_pend),
        .intr_timeout    (intr_timeout)
    );

    typedef struct {
        bit       rst;
        bit       vld;
        bit [3:0] pend;
        bit       to;
    } cyc_exp_t;

    typedef struct {
        int op;
        int cyc;
    } req_exp_t;

    cyc_exp_t cq[$];
    req_exp_t rq[$];
    int       cyc = 0;
    int       checks = 0;
    int       errors = 0;

    // Reference state: what the controller is doing in the current cycle.
    bit [3:0] m_pend;
    bit       m_req, m_busy, m_to;
    int       m_age, m_op, m_grant;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int pick(input bit [3:0] elig);
        for (int k = 0; k < 4; k++)
            if (elig[ORDER[k]]) return ORDER[k];
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_req = 0; m_busy = 0; m_to = 0; m_age = 0; m_op = 0; m_grant = 0;
    endtask

    task automatic model_step();
        bit [3:0] elig;
        bit [3:0] nxt;
        int       w;
        bit       hs;
        hs         = m_req && rdy;
        elig       = '0;
        elig[3]    = m_pend[3];
        elig[2]    = m_pend[2] && mie && meie;
        elig[0]    = m_pend[0] && mie && msie;
`ifdef TOY_INTR_TIMER_EN
        elig[1]    = m_pend[1] && mie && mtie;
`endif
        nxt = m_pend;
        if (hs) nxt[m_grant] = 1'b0;
        nxt = nxt | {dbg, meip, mtip, msip};
        m_to = 0;
        if (m_busy) begin
            if (clr) m_busy = 0;
            else if (m_age == TO - 1) begin m_busy = 0; m_to = 1; end
            else m_age++;
        end else if (m_req) begin
            if (rdy) begin m_req = 0; m_busy = 1; m_age = 0; end
        end else begin
            w = pick(elig);
            if (w >= 0) begin
                m_req = 1; m_op = OPS[w]; m_grant = w;
                rq.push_back('{op: OPS[w], cyc: cyc + 1});
            end
        end
        m_pend = nxt;
    endtask

    // Monitor: per-cycle state check plus request scoreboard on every new intr_vld.
    initial begin
        cyc_exp_t e;
        req_exp_t r;
        bit       prev_vld = 0;
        int       cur_op = 0;
        forever begin
            @(negedge clk);
            if (cq.size() == 0) continue;
            e = cq.pop_front();
            chk("vld", int'(intr_vld), int'(e.vld));
            chk("pend", int'(intr_pend), int'(e.pend));
            chk("timeout", int'(intr_timeout), int'(e.to));
            if (e.rst) chk("rst_op", int'(intr_op), 0);
            if (intr_vld && !prev_vld) begin
                if (rq.size() == 0) begin
                    chk("unexpected_req", 1, 0);
                end else begin
                    r = rq.pop_front();
                    chk("req_op", int'(intr_op), r.op);
                    chk("req_cycle", cyc, r.cyc);
                    cur_op = r.op;
                    $display("req cycle %0d op %0d pend %b", cyc, intr_op, intr_pend);
                end
            end else if (intr_vld) begin
                chk("op_stable", int'(intr_op), cur_op);
            end
            if (intr_timeout) $display("timeout cycle %0d", cyc);
            prev_vld = intr_vld;
        end
    end

    // Driver: random stimulus with phased enable patterns and a few targeted corners.
    initial begin
        int  rst_hold = 0;
        bit  want_reset = 0;
        int  phase;
        model_reset();
        for (int i = 0; i < NCYC; i++) begin
            @(posedge clk);
            #1;
            phase = (i / 500) % 4;
            meip = ($urandom_range(0, 7) == 0);
            msip = ($urandom_range(0, 7) == 0);
            dbg  = ($urandom_range(0, 11) == 0);
`ifdef TOY_INTR_TIMER_EN
            mtip = ($urandom_range(0, 7) == 0);
`else
            mtip = 1'b0;
`endif
            case (phase)
                0: begin mie = 1; meie = 1; msie = 1; mtie = 1; end
                1: begin
                    if ($urandom_range(0, 15) == 0) mie  = ~mie;
                    if ($urandom_range(0, 15) == 0) meie = ~meie;
                    if ($urandom_range(0, 15) == 0) msie = ~msie;
                    if ($urandom_range(0, 15) == 0) mtie = ~mtie;
                end
                2: begin mie = 0; meie = 0; msie = 0; mtie = 0; end
                default: begin
                    mie = 1;
                    meie = 1'($urandom_range(0, 1));
                    msie = 1'($urandom_range(0, 1));
                    mtie = 1'($urandom_range(0, 1));
                end
            endcase
            rdy = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 9) == 0);
            // Re-pend ext on its own handshake; clear exactly on the timeout cycle.
            if (m_req && rdy && m_grant == 2 && $urandom_range(0, 1) == 1) meip = 1;
            if (m_busy && m_age == TO - 1 && $urandom_range(0, 2) == 0) clr = 1;
            if (i % 900 == 450) want_reset = 1;
            if (i < 3) begin
                rst_n = 0;
            end else if (rst_hold > 0) begin
                rst_n = 0; rst_hold--;
            end else if (want_reset && m_req) begin
                rst_n = 0; rst_hold = 1; want_reset = 0;
            end else begin
                rst_n = 1;
            end
            if (!rst_n) begin
                model_reset();
                rq.delete();
            end
            cq.push_back('{rst: !rst_n, vld: m_req, pend: m_pend, to: m_to});
            if (rst_n) model_step();
        end
        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
